uart_resp_encoder: RTL and testbench

- Transmit-side counterpart to the UART command parser.
- Turns SDRAM controller completion events into ASCII response frames and drives the byte-wide uart_tx (data/send/busy).
- Read completion (rd_data, rd_ready) produces "R" + 4 hex digits + EOL; write completion (wr_done) produces "K" + EOL.
- Sits between sdram_ctrl and uart_tx in the CLOCK_50 domain; events are already synchronised into this domain.

---
 rtl/uart_resp_encoder.sv | 220 ++++++++++++++++++++++
 tb/tb_uart_resp_encoder.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_resp_encoder.sv
// Response framer: turns SDRAM read/write completions into ASCII frames for uart_tx.
// Optional UART_RESP_ADDR_EN adds the 24-bit event address (6 hex digits) to every frame.
//
// state  | meaning
// S_IDLE | no frame; start from pending buffer first, else from an event this cycle
// S_LOAD | tx_send high for one cycle with tx_data holding the current byte
// S_ARM  | one cycle grace while uart_tx raises tx_busy
// S_WAIT | hold until tx_busy drops, then next byte or back to idle
module uart_resp_encoder #(
   parameter bit HEX_UPPER = 1'b1,
   parameter bit EOL_CR    = 1'b1
) (
   input  logic        clk,
   input  logic        rst_n,
`ifdef UART_RESP_ADDR_EN
   input  logic [23:0] evt_addr,
`endif
   input  logic [15:0] rd_data,
   input  logic        rd_ready,
   input  logic        wr_done,
   output logic [7:0]  tx_data,
   output logic        tx_send,
   input  logic        tx_busy,
   output logic        enc_busy,
   output logic        overflow
);

`ifdef UART_RESP_ADDR_EN
   localparam int IW      = 4;
   localparam int RD_BODY = 12;
   localparam int WR_BODY = 7;
`else
   localparam int IW      = 3;
   localparam int RD_BODY = 5;
   localparam int WR_BODY = 1;
`endif
   localparam int EOL_LEN = EOL_CR ? 2 : 1;
   localparam logic [IW-1:0] RD_LAST = IW'(RD_BODY + EOL_LEN - 1);
   localparam logic [IW-1:0] WR_LAST = IW'(WR_BODY + EOL_LEN - 1);

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_ARM, S_WAIT} state_t;

   state_t        state;
   logic [IW-1:0] byte_idx;
   logic          cur_rd;
   logic [15:0]   cur_data;
   logic          pend_full;
   logic          pend_rd;
   logic [15:0]   pend_data;
`ifdef UART_RESP_ADDR_EN
   logic [23:0]   cur_addr, pend_addr, start_addr;
`endif

   logic          start_go, start_rd, buf_go, buf_rd, drop;
   logic [15:0]   start_data;

   function automatic logic [7:0] hex_char(input logic [3:0] n);
      if (n < 4'd10)  return 8'h30 + {4'h0, n};
      else if (HEX_UPPER) return 8'h37 + {4'h0, n};
      else            return 8'h57 + {4'h0, n};
   endfunction

   function automatic logic [3:0] nib16(input logic [15:0] d, input logic [1:0] k);
      case (k)
         2'd0:    return d[15:12];
         2'd1:    return d[11:8];
         2'd2:    return d[7:4];
         default: return d[3:0];
      endcase
   endfunction

`ifdef UART_RESP_ADDR_EN
   function automatic logic [3:0] nib24(input logic [23:0] a, input logic [2:0] k);
      case (k)
         3'd0:    return a[23:20];
         3'd1:    return a[19:16];
         3'd2:    return a[15:12];
         3'd3:    return a[11:8];
         3'd4:    return a[7:4];
         3'd5:    return a[3:0];
         default: return 4'h0;
      endcase
   endfunction
`endif

   // Byte idx of a frame: tag, hex payload, then EOL starting at the body length.
   function automatic logic [7:0] frame_byte(
      input logic          rd,
      input logic [15:0]   d,
`ifdef UART_RESP_ADDR_EN
      input logic [23:0]   a,
`endif
      input logic [IW-1:0] idx);
      logic [IW-1:0] body;
      body = rd ? IW'(RD_BODY) : IW'(WR_BODY);
      if (idx == '0)
         return rd ? 8'h52 : 8'h4B;
      else if (idx >= body)
         return (EOL_CR && idx == body) ? 8'h0D : 8'h0A;
`ifdef UART_RESP_ADDR_EN
      else if (idx <= IW'(6))
         return hex_char(nib24(a, 3'(idx - IW'(1))));
      else if (idx == IW'(7))
         return 8'h3A;
      else
         return hex_char(nib16(d, 2'(idx - IW'(8))));
`else
      else
         return hex_char(nib16(d, 2'(idx - IW'(1))));
`endif
   endfunction

   // Read wins the frame slot; the buffer slot frees in the same cycle it is consumed.
   always_comb begin
      start_go   = 1'b0;
      start_rd   = 1'b0;
      start_data = 16'h0000;
      buf_go     = 1'b0;
      buf_rd     = 1'b0;
      drop       = 1'b0;
`ifdef UART_RESP_ADDR_EN
      start_addr = evt_addr;
`endif
      if (state == S_IDLE && pend_full) begin
         start_go   = 1'b1;
         start_rd   = pend_rd;
         start_data = pend_data;
`ifdef UART_RESP_ADDR_EN
         start_addr = pend_addr;
`endif
         buf_go     = rd_ready | wr_done;
         buf_rd     = rd_ready;
         drop       = rd_ready & wr_done;
      end else if (state == S_IDLE) begin
         start_go   = rd_ready | wr_done;
         start_rd   = rd_ready;
         start_data = rd_data;
         buf_go     = rd_ready & wr_done;
         buf_rd     = 1'b0;
      end else begin
         buf_go     = (rd_ready | wr_done) & ~pend_full;
         buf_rd     = rd_ready;
         drop       = ((rd_ready | wr_done) & pend_full) | (rd_ready & wr_done);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         byte_idx  <= '0;
         cur_rd    <= 1'b0;
         cur_data  <= 16'h0000;
         pend_full <= 1'b0;
         pend_rd   <= 1'b0;
         pend_data <= 16'h0000;
         tx_data   <= 8'h00;
         tx_send   <= 1'b0;
         overflow  <= 1'b0;
`ifdef UART_RESP_ADDR_EN
         cur_addr  <= 24'h0;
         pend_addr <= 24'h0;
`endif
      end else begin
         if (drop)
            overflow <= 1'b1;
         if (buf_go) begin
            pend_full <= 1'b1;
            pend_rd   <= buf_rd;
            pend_data <= rd_data;
`ifdef UART_RESP_ADDR_EN
            pend_addr <= evt_addr;
`endif
         end else if (state == S_IDLE && pend_full) begin
            pend_full <= 1'b0;
         end
         case (state)
            S_IDLE: begin
               if (start_go) begin
                  cur_rd   <= start_rd;
                  cur_data <= start_data;
                  byte_idx <= '0;
`ifdef UART_RESP_ADDR_EN
                  cur_addr <= start_addr;
                  tx_data  <= frame_byte(start_rd, start_data, start_addr, '0);
`else
                  tx_data  <= frame_byte(start_rd, start_data, '0);
`endif
                  tx_send  <= 1'b1;
                  state    <= S_LOAD;
               end
            end
            S_LOAD: begin
               tx_send <= 1'b0;
               state   <= S_ARM;
            end
            S_ARM: state <= S_WAIT;
            S_WAIT: begin
               if (!tx_busy) begin
                  if (byte_idx == (cur_rd ? RD_LAST : WR_LAST)) begin
                     state <= S_IDLE;
                  end else begin
                     byte_idx <= byte_idx + IW'(1);
`ifdef UART_RESP_ADDR_EN
                     tx_data  <= frame_byte(cur_rd, cur_data, cur_addr, byte_idx + IW'(1));
`else
                     tx_data  <= frame_byte(cur_rd, cur_data, byte_idx + IW'(1));
`endif
                     tx_send  <= 1'b1;
                     state    <= S_LOAD;
                  end
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign enc_busy = (state != S_IDLE) || pend_full;

endmodule

// File: tb/tb_uart_resp_encoder.sv
// Bench for uart_resp_encoder: instance a (upper hex, CR LF) and instance b (lower hex, LF only).
// Expected bytes are queued when events are driven and popped as tx_send pulses appear.
module tb_uart_resp_encoder;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic [15:0] a_rd_data, b_rd_data;
   logic        a_rd_ready, a_wr_done, b_rd_ready, b_wr_done;
   logic [7:0]  a_tx_data, b_tx_data;
   logic        a_tx_send, b_tx_send, a_tx_busy, b_tx_busy;
   logic        a_enc_busy, b_enc_busy, a_overflow, b_overflow;
   int          a_cnt, b_cnt;
   int          cyc = 0;
   int          errors = 0;
   int          checks = 0;
   logic [7:0]  qa[$];
   logic [7:0]  qb[$];

   uart_resp_encoder #(.HEX_UPPER(1'b1), .EOL_CR(1'b1)) u_a (
      .clk(clk), .rst_n(rst_n), .rd_data(a_rd_data), .rd_ready(a_rd_ready),
      .wr_done(a_wr_done), .tx_data(a_tx_data), .tx_send(a_tx_send),
      .tx_busy(a_tx_busy), .enc_busy(a_enc_busy), .overflow(a_overflow));

   uart_resp_encoder #(.HEX_UPPER(1'b0), .EOL_CR(1'b0)) u_b (
      .clk(clk), .rst_n(rst_n), .rd_data(b_rd_data), .rd_ready(b_rd_ready),
      .wr_done(b_wr_done), .tx_data(b_tx_data), .tx_send(b_tx_send),
      .tx_busy(b_tx_busy), .enc_busy(b_enc_busy), .overflow(b_overflow));

   // uart_tx stand-ins: busy for 10 cycles after each load
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n)         a_cnt <= 0;
      else if (a_tx_send) a_cnt <= 10;
      else if (a_cnt > 0) a_cnt <= a_cnt - 1;
   end
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n)         b_cnt <= 0;
      else if (b_tx_send) b_cnt <= 10;
      else if (b_cnt > 0) b_cnt <= b_cnt - 1;
   end
   assign a_tx_busy = (a_cnt != 0);
   assign b_tx_busy = (b_cnt != 0);

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] hexc(input logic [3:0] n, input bit up);
      if (n < 4'd10) return 8'h30 + {4'h0, n};
      if (up)        return 8'h41 + {4'h0, n} - 8'd10;
      return 8'h61 + {4'h0, n} - 8'd10;
   endfunction

   task automatic push(input bit sel, input logic [7:0] b);
      if (sel) qb.push_back(b);
      else     qa.push_back(b);
   endtask

   // sel=0 -> instance a (upper, CR LF); sel=1 -> instance b (lower, LF)
   task automatic exp_read(input bit sel, input logic [15:0] d);
      push(sel, 8'h52);
      for (int i = 3; i >= 0; i--) push(sel, hexc(d[i*4 +: 4], !sel));
      if (!sel) push(sel, 8'h0D);
      push(sel, 8'h0A);
   endtask

   task automatic exp_write(input bit sel);
      push(sel, 8'h4B);
      if (!sel) push(sel, 8'h0D);
      push(sel, 8'h0A);
   endtask

   task automatic pulse(input bit sel, input logic rd, input logic wr, input logic [15:0] d);
      @(negedge clk);
      if (sel) begin b_rd_ready = rd; b_wr_done = wr; b_rd_data = d; end
      else     begin a_rd_ready = rd; a_wr_done = wr; a_rd_data = d; end
      @(negedge clk);
      a_rd_ready = 1'b0; a_wr_done = 1'b0; b_rd_ready = 1'b0; b_wr_done = 1'b0;
   endtask

   task automatic drain(input bit sel, input int n, input string tag);
      logic [7:0] got, exp;
      int t;
      for (int i = 0; i < n; i++) begin
         t = 0;
         while (!(sel ? b_tx_send : a_tx_send) && t < 300) begin
            @(negedge clk);
            t++;
         end
         if (t >= 300) begin
            chk({tag, " timeout"}, 32'(sel ? b_tx_send : a_tx_send), 32'd1);
            return;
         end
         got = sel ? b_tx_data : a_tx_data;
         exp = 8'hxx;
         if (sel && qb.size() > 0)       exp = qb.pop_front();
         else if (!sel && qa.size() > 0) exp = qa.pop_front();
         chk($sformatf("%s byte%0d", tag, i), 32'(got), 32'(exp));
         @(negedge clk);
         chk({tag, " send one cycle"}, 32'(sel ? b_tx_send : a_tx_send), 32'd0);
      end
   endtask

   task automatic wait_idle(input bit sel, input string tag);
      int t = 0;
      while ((sel ? b_enc_busy : a_enc_busy) && t < 500) begin
         @(negedge clk);
         t++;
      end
      chk({tag, " idle"}, 32'(sel ? b_enc_busy : a_enc_busy), 32'd0);
   endtask

   initial begin
      int extra;
      int t;
      rst_n = 1'b0;
      a_rd_ready = 1'b0; a_wr_done = 1'b0; a_rd_data = 16'h0;
      b_rd_ready = 1'b0; b_wr_done = 1'b0; b_rd_data = 16'h0;
      repeat (3) @(negedge clk);
      chk("rst tx_data", 32'(a_tx_data), 32'h00);
      chk("rst tx_send", 32'(a_tx_send), 32'd0);
      chk("rst enc_busy", 32'(a_enc_busy), 32'd0);
      chk("rst overflow", 32'(a_overflow), 32'd0);
      chk("rst b tx_data", 32'(b_tx_data), 32'h00);
      rst_n = 1'b1;
      @(negedge clk);

      // read frame, upper case, CR LF
      exp_read(0, 16'hA55A);
      pulse(0, 1'b1, 1'b0, 16'hA55A);
      chk("rd latency", 32'(a_tx_send), 32'd1);
      drain(0, 7, "rd_a55a");
      wait_idle(0, "rd_a55a");
      chk("rd_a55a overflow", 32'(a_overflow), 32'd0);

      // write ack, LF only; enc_busy drops one cycle after last busy drop
      exp_write(1);
      pulse(1, 1'b0, 1'b1, 16'h0);
      chk("wr latency", 32'(b_tx_send), 32'd1);
      drain(1, 2, "wr_b");
      chk("wr enc_busy during byte", 32'(b_enc_busy), 32'd1);
      t = 0;
      while (b_tx_busy && t < 100) begin @(negedge clk); t++; end
      chk("wr enc_busy at busy drop", 32'(b_enc_busy), 32'd1);
      @(negedge clk);
      chk("wr enc_busy after", 32'(b_enc_busy), 32'd0);

      // simultaneous read and write
      exp_read(0, 16'h00F3);
      exp_write(0);
      pulse(0, 1'b1, 1'b1, 16'h00F3);
      chk("simul enc_busy", 32'(a_enc_busy), 32'd1);
      drain(0, 10, "simul");
      wait_idle(0, "simul");
      chk("simul overflow", 32'(a_overflow), 32'd0);

      // overflow: write buffered mid-frame, later read dropped
      exp_read(0, 16'h1111);
      exp_write(0);
      pulse(0, 1'b1, 1'b0, 16'h1111);
      drain(0, 1, "ovf");
      pulse(0, 1'b0, 1'b1, 16'h0);
      chk("ovf after buffered wr", 32'(a_overflow), 32'd0);
      repeat (3) @(negedge clk);
      pulse(0, 1'b1, 1'b0, 16'h2222);
      chk("ovf set", 32'(a_overflow), 32'd1);
      drain(0, 9, "ovf");
      wait_idle(0, "ovf");
      extra = 0;
      repeat (30) begin @(negedge clk); if (a_tx_send) extra++; end
      chk("ovf dropped frame", 32'(extra), 32'd0);
      chk("ovf sticky", 32'(a_overflow), 32'd1);

      // lower-case hex
      exp_read(1, 16'hBEEF);
      pulse(1, 1'b1, 1'b0, 16'hBEEF);
      drain(1, 6, "lower");
      wait_idle(1, "lower");

      // reset while the third byte is being loaded
      exp_read(0, 16'hC3D2);
      pulse(0, 1'b1, 1'b0, 16'hC3D2);
      drain(0, 2, "rstmid");
      t = 0;
      while (!a_tx_send && t < 300) begin @(negedge clk); t++; end
      chk("rstmid byte2", 32'(a_tx_data), 32'(qa.size() > 0 ? qa[0] : 8'hxx));
      #1 rst_n = 1'b0;
      #1;
      chk("rstmid tx_send", 32'(a_tx_send), 32'd0);
      chk("rstmid tx_data", 32'(a_tx_data), 32'h00);
      chk("rstmid enc_busy", 32'(a_enc_busy), 32'd0);
      chk("rstmid overflow", 32'(a_overflow), 32'd0);
      qa.delete();
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      extra = 0;
      repeat (40) begin @(negedge clk); if (a_tx_send) extra++; end
      chk("rstmid no resume", 32'(extra), 32'd0);
      exp_read(0, 16'h1234);
      pulse(0, 1'b1, 1'b0, 16'h1234);
      chk("post-rst latency", 32'(a_tx_send), 32'd1);
      drain(0, 7, "post_rst");
      wait_idle(0, "post_rst");
      chk("post_rst overflow", 32'(a_overflow), 32'd0);
      chk("queue a empty", 32'(qa.size()), 32'd0);
      chk("queue b empty", 32'(qb.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
